// File: rtl/input_debounce.sv
// Two-flop synchroniser plus per-channel stability counter for 5 buttons and 16 switches.
// Buttons also get a registered one-cycle pulse on each accepted 0->1 transition.
//
// Per-channel state (derived from sync2 vs stable, never stored):
//   state    | meaning
//   IDLE     | sync2 == stable, counter held at 0
//   COUNTING | sync2 != stable, counter advancing toward DEBOUNCE_CYCLES-1

module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_butten_raw,
  input  logic [15:0] in_swi_raw,
  output logic [4:0]  out_butten,
  output logic [15:0] out_swi,
  output logic [4:0]  out_butten_press
);

  localparam int N_BTN = 5;
  localparam int N_SW  = 16;
  localparam int N_CH  = N_BTN + N_SW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Buttons occupy the low channel indices, switches the high ones.
  logic [N_CH-1:0]  raw_all;
  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [N_CH-1:0]  stable;
  logic [N_CH-1:0]  stable_nxt;
  logic [N_CH-1:0]  counting;
  logic [CNT_W-1:0] cnt     [N_CH];
  logic [CNT_W-1:0] cnt_nxt [N_CH];
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_nxt;

  assign raw_all  = {in_swi_raw, in_butten_raw};
  assign counting = sync2 ^ stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      press_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw_all;
      sync2   <= sync1;
      stable  <= stable_nxt;
      press_q <= press_nxt;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // A match aborts the count; a full run of mismatches accepts the new level.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = '0;
      if (counting[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
    press_nxt = stable_nxt[N_BTN-1:0] & ~stable[N_BTN-1:0];
  end

  always_comb begin
    out_butten       = stable[N_BTN-1:0];
    out_swi          = stable[N_CH-1:N_BTN];
    out_butten_press = press_q;
  end

endmodule

// File: doc/input_debounce.md
# input_debounce

Synchronises and debounces the raw FPGA push-button and slide-switch pins before they reach the memory-mapped device port. The device port samples the `in_butten` and `in_swi` inputs into its read-only button/switch registers; this block drives those inputs. It also produces one-cycle press pulses per button for any future interrupt or edge-capture logic. It uses the single system clock, with a two-flop synchroniser and an independent stability counter per channel.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive cycles a synchronised level must differ from the stable value before it is accepted. The default gives 10 ms at 100 MHz. Legal range is 1 .. 2^CNT_W−1.
- `CNT_W`, default 20: width of each per-channel counter.

Ports:
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `in_butten_raw` input 5: raw, asynchronous button pins; 1 means pressed.
- `in_swi_raw` input 16: raw, asynchronous switch pins.
- `out_butten` output 5: debounced button levels; connects to the device port's `in_butten`.
- `out_swi` output 16: debounced switch levels; connects to the device port's `in_swi`.
- `out_butten_press` output 5: one-cycle pulse for each debounced 0→1 button transition.

## Operation
- The block has 21 identical channels: buttons 0–4 and switches 0–15. Each channel holds:
  - `sync1` and `sync2`, the synchroniser flops;
  - `stable`, the debounced value;
  - `cnt[CNT_W-1:0]`, the stability counter.
- Every edge, per channel:
  - `sync1` <= raw.
  - `sync2` <= `sync1`.
  - If `sync2 == stable`: `cnt` <= 0.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `stable` <= `sync2` and `cnt` <= 0.
  - Else: `cnt` <= `cnt+1`.
- The per-channel state is implicit: IDLE when `sync2==stable`, COUNTING otherwise.
  - A return of `sync2` to the stable value during COUNTING aborts the count; `cnt` returns to 0 and `stable` is unchanged.
  - Counting restarts from 0 on the next mismatch.
- `out_butten` and `out_swi` are the `stable` registers.
- `out_butten_press[i]` is registered. It is 1 for exactly the one cycle in which `out_butten[i]` first reads 1 after having been 0, and 0 otherwise.
- Switches have no press pulse.
- Release transitions (1→0) produce no pulse.
- Channels are fully independent. Simultaneous transitions on several channels each complete at their own time with no interaction.
- The counter never wraps: it resets at `DEBOUNCE_CYCLES-1` or on a match.

## Timing
- Reset (`rst`=1 at an edge) clears every `sync1`, `sync2`, `stable`, `cnt` and press register to 0.
  - After reset: `out_butten`=0, `out_swi`=0, `out_butten_press`=0.
  - Reset takes priority over all other updates, including a count that would complete on the same edge.
- Reset mid-count discards the count.
  - A pin still held at 1 after reset is re-debounced from scratch.
  - A button held through reset therefore yields a press pulse `DEBOUNCE_CYCLES`+1 edges after `rst` deasserts.
- Latency: raw level sampled into `sync1` at edge k, held steady, gives:
  - `sync2` updated at edge k+1;
  - `stable` updated at edge k+1+`DEBOUNCE_CYCLES`;
  - the press pulse high during the cycle following that edge.
- Glitch rejection: any `sync2` excursion lasting fewer than `DEBOUNCE_CYCLES` cycles never reaches `stable`.
- `DEBOUNCE_CYCLES`=1: a single mismatched `sync2` cycle is accepted, so latency is edge k+2.
- There is no combinational path from any input to any output.

## Test plan
For all scenarios, `DEBOUNCE_CYCLES`=4 and `CNT_W`=4.
- **Reset:** drive `rst`=1 for 2 edges with all raw pins=1. Required: all outputs 0 while in reset. After release, `out_swi`=16'hFFFF and `out_butten`=5'h1F exactly 5 edges after the first post-reset sample. `out_butten_press`=5'h1F for exactly 1 cycle.
- **Clean press:** raise `in_butten_raw[2]` before edge 0 and hold it. Required:
  - `out_butten`=5'h04 from edge 5.
  - `out_butten_press`=5'h04 only in the cycle after edge 5.
  - Release: `out_butten`=0 five edges after the release is sampled, with no pulse.
- **Bounce:** toggle `in_swi_raw[7]` 1,0,1,0 with each level lasting 3 cycles, then hold at 1. Required: `out_swi[7]` stays 0 during the bounce and rises 5 edges after the final rise is sampled.
- **Simultaneous events:** change all 16 switches to 16'hA5C3 and button 0 to 1 on the same edge. Required: `out_swi`=16'hA5C3 and `out_butten[0]`=1 on the same edge, k+5.
- **Reset mid-count:** hold `in_butten_raw[4]`=1, then assert `rst` for 1 cycle when `cnt`=2. Required: no press pulse before the reset. After the reset, `out_butten[4]` rises 5 edges after the first post-reset sample.
- **Single-cycle glitch:** pulse `in_swi_raw[0]` high for 1 cycle. Required: `out_swi` stays 16'h0000 throughout.
